// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive packet path.
// Optional feature macro used by this slice: USB_RX_SOF_EN (SOF token decode).
package usb_pkg;

  // 4-bit PID as carried in PID[3:0]; PID[7:4] is the one's complement check field.
  typedef enum logic [3:0] {
    PidRsvd  = 4'b0000,
    PidOut   = 4'b0001,
    PidAck   = 4'b0010,
    PidData0 = 4'b0011,
    PidPing  = 4'b0100,
    PidSof   = 4'b0101,
    PidNyet  = 4'b0110,
    PidData2 = 4'b0111,
    PidSplit = 4'b1000,
    PidIn    = 4'b1001,
    PidNak   = 4'b1010,
    PidData1 = 4'b1011,
    PidPre   = 4'b1100,
    PidSetup = 4'b1101,
    PidStall = 4'b1110,
    PidMdata = 4'b1111
  } pid_e;

  typedef enum logic [2:0] {
    StIdle,
    StTok,
    StData,
    StHs,
    StCheck,
    StDrain
  } rx_state_e;

  typedef enum logic [2:0] {
    ErrNone   = 3'd0,
    ErrPid    = 3'd1,
    ErrCrc5   = 3'd2,
    ErrCrc16  = 3'd3,
    ErrLen    = 3'd4,
    ErrBabble = 3'd5,
    ErrAbort  = 3'd6
  } err_code_e;

  localparam logic [4:0]  USB_CRC5_INIT     = 5'b11111;
  localparam logic [4:0]  USB_CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  USB_CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] USB_CRC16_RESIDUE = 16'h800D;

  // Advance CRC5 by one byte, bits taken LSB first as they appear on the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = data[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? USB_CRC5_POLY : 5'b00000);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_packet_ctrl_if.sv
// Byte-stream, data-engine and result signals of the rx packet sequencer.
// USB_RX_SOF_EN adds the SOF result signals (sof_valid, frame_num).
interface usb_rx_packet_ctrl_if;

  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_eop;
  logic        rx_abort;
  logic        eng_crc_error;
  logic        eng_load_data;
  logic [7:0]  eng_data;
  logic        eng_packet_done;
  logic [3:0]  pkt_pid;
  logic        token_valid;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic        hs_valid;
  logic        data_ok;
  logic        err_valid;
  logic [2:0]  err_code;
`ifdef USB_RX_SOF_EN
  logic        sof_valid;
  logic [10:0] frame_num;
`endif

  // Stimulus side: PHY decode, data engine verdict, protocol layer.
  modport master (
    output rx_byte_valid, rx_byte, rx_eop, rx_abort, eng_crc_error,
    input  eng_load_data, eng_data, eng_packet_done, pkt_pid, token_valid, token_addr,
    input  token_endp, hs_valid, data_ok, err_valid, err_code
`ifdef USB_RX_SOF_EN
    , input sof_valid, frame_num
`endif
  );

  // Sequencer side.
  modport slave (
    input  rx_byte_valid, rx_byte, rx_eop, rx_abort, eng_crc_error,
    output eng_load_data, eng_data, eng_packet_done, pkt_pid, token_valid, token_addr,
    output token_endp, hs_valid, data_ok, err_valid, err_code
`ifdef USB_RX_SOF_EN
    , output sof_valid, frame_num
`endif
  );

endinterface

// File: rtl/usb_crc5_check.sv
// Serial-in-byte CRC5 accumulator for token checking.
module usb_crc5_check
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       nRST,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] data,
  output logic       residue_ok
);

  logic [4:0] crc_q, crc_d;

  // Next CRC value: clear wins over load.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = USB_CRC5_INIT;
    end else if (load) begin
      crc_d = crc5_byte(crc_q, data);
    end
  end

  // Judged on the post-load value so a last byte arriving with EOP is included.
  assign residue_ok = (crc_d == USB_CRC5_RESIDUE);

  // CRC state register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      crc_q <= USB_CRC5_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// Receive-side packet sequencer: PID check, token CRC5, data engine strobes, one
// result per packet. USB_RX_SOF_EN enables SOF decode with frame number output.
module usb_rx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 1026
) (
  input logic                 clk,
  input logic                 nRST,
  usb_rx_packet_ctrl_if.slave bus
);

  localparam logic [10:0] CntMax = 11'(MAX_DATA_BYTES);
  localparam logic [10:0] CntSat = 11'(MAX_DATA_BYTES + 1);

  rx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  b1_q, b1_d;
  logic [2:0]  b2_q, b2_d;
  logic [3:0]  pid_q, pid_d;
  logic        load_q, load_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        tok_q, tok_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic        hs_q, hs_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  err_code_e   code_q, code_d;
  logic        crc_clear, crc_load, crc_ok;
`ifdef USB_RX_SOF_EN
  logic        is_sof_q, is_sof_d;
  logic        sof_q, sof_d;
  logic [10:0] frame_q, frame_d;
`endif

  usb_crc5_check u_crc5 (
    .clk        (clk),
    .nRST       (nRST),
    .clear      (crc_clear),
    .load       (crc_load),
    .data       (bus.rx_byte),
    .residue_ok (crc_ok)
  );

  // Next state and registered outputs: abort first, else byte then EOP, then verdict.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    pid_d     = pid_q;
    load_d    = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    tok_d     = 1'b0;
    addr_d    = addr_q;
    endp_d    = endp_q;
    hs_d      = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    crc_clear = 1'b0;
    crc_load  = 1'b0;
`ifdef USB_RX_SOF_EN
    is_sof_d  = is_sof_q;
    sof_d     = 1'b0;
    frame_d   = frame_q;
`endif

    if (bus.rx_abort) begin
      unique case (state_q)
        StIdle:  ;
        StDrain: state_d = StIdle;
        default: begin
          // Flush the engine CRC; the aborted packet gets no CRC16 verdict.
          done_d  = (state_q == StData);
          err_d   = 1'b1;
          code_d  = ErrAbort;
          state_d = StIdle;
        end
      endcase
    end else begin
      if (bus.rx_byte_valid) begin
        unique case (state_q)
          StIdle: begin
            cnt_d     = '0;
            crc_clear = 1'b1;
            if (bus.rx_byte[3:0] != ~bus.rx_byte[7:4]) begin
              err_d   = 1'b1;
              code_d  = ErrPid;
              state_d = StDrain;
            end else begin
              pid_d = bus.rx_byte[3:0];
`ifdef USB_RX_SOF_EN
              is_sof_d = 1'b0;
`endif
              case (pid_e'(bus.rx_byte[3:0]))
                PidOut, PidIn, PidSetup:            state_d = StTok;
                PidData0, PidData1, PidData2, PidMdata: state_d = StData;
                PidAck, PidNak, PidStall, PidNyet:  state_d = StHs;
`ifdef USB_RX_SOF_EN
                PidSof: begin
                  state_d  = StTok;
                  is_sof_d = 1'b1;
                end
`endif
                default:                            state_d = StDrain;
              endcase
            end
          end
          StTok: begin
            if (cnt_q == 11'd2) begin
              err_d   = 1'b1;
              code_d  = ErrLen;
              state_d = StDrain;
            end else begin
              cnt_d    = cnt_q + 11'd1;
              crc_load = 1'b1;
              if (cnt_q == 11'd0) begin
                b1_d = bus.rx_byte;
              end else begin
                b2_d = bus.rx_byte[2:0];
              end
            end
          end
          StHs: begin
            err_d   = 1'b1;
            code_d  = ErrLen;
            state_d = StDrain;
          end
          StData: begin
            if (cnt_q == CntMax) begin
              // Overflow byte is not forwarded.
              cnt_d   = CntSat;
              err_d   = 1'b1;
              code_d  = ErrBabble;
              done_d  = 1'b1;
              state_d = StDrain;
            end else begin
              cnt_d  = cnt_q + 11'd1;
              load_d = 1'b1;
              data_d = bus.rx_byte;
            end
          end
          default: ;
        endcase
      end

      // EOP is applied to the state left by any byte in the same cycle.
      if (bus.rx_eop) begin
        unique case (state_d)
          StTok: begin
            state_d = StIdle;
            if (cnt_d != 11'd2) begin
              err_d  = 1'b1;
              code_d = ErrLen;
            end else if (!crc_ok) begin
              err_d  = 1'b1;
              code_d = ErrCrc5;
`ifdef USB_RX_SOF_EN
            end else if (is_sof_d) begin
              sof_d   = 1'b1;
              frame_d = {b2_d, b1_d};
`endif
            end else begin
              tok_d  = 1'b1;
              addr_d = b1_d[6:0];
              endp_d = {b2_d, b1_d[7]};
            end
          end
          StHs: begin
            hs_d    = 1'b1;
            state_d = StIdle;
          end
          StData: begin
            done_d  = 1'b1;
            state_d = StCheck;
          end
          StDrain: state_d = StIdle;
          default: ;
        endcase
      end

      // Engine verdict is valid the cycle after packet_done, so wait out that strobe.
      if (state_q == StCheck && !done_q) begin
        state_d = StIdle;
        if (cnt_q < 11'd2) begin
          err_d  = 1'b1;
          code_d = ErrLen;
        end else if (bus.eng_crc_error) begin
          err_d  = 1'b1;
          code_d = ErrCrc16;
        end else begin
          ok_d = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      pid_q    <= '0;
      load_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      tok_q    <= 1'b0;
      addr_q   <= '0;
      endp_q   <= '0;
      hs_q     <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
`ifdef USB_RX_SOF_EN
      is_sof_q <= 1'b0;
      sof_q    <= 1'b0;
      frame_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      pid_q    <= pid_d;
      load_q   <= load_d;
      data_q   <= data_d;
      done_q   <= done_d;
      tok_q    <= tok_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      hs_q     <= hs_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
`ifdef USB_RX_SOF_EN
      is_sof_q <= is_sof_d;
      sof_q    <= sof_d;
      frame_q  <= frame_d;
`endif
    end
  end

  assign bus.eng_load_data   = load_q;
  assign bus.eng_data        = data_q;
  assign bus.eng_packet_done = done_q;
  assign bus.pkt_pid         = pid_q;
  assign bus.token_valid     = tok_q;
  assign bus.token_addr      = addr_q;
  assign bus.token_endp      = endp_q;
  assign bus.hs_valid        = hs_q;
  assign bus.data_ok         = ok_q;
  assign bus.err_valid       = err_q;
  assign bus.err_code        = code_q;
`ifdef USB_RX_SOF_EN
  assign bus.sof_valid       = sof_q;
  assign bus.frame_num       = frame_q;
`endif

endmodule
